q_meas_regfile: RTL and testbench

Parametrised measurement-result register file for the quantum controller (QC). It collects single-bit qubit measurement outcomes from NUM_WR_CH independent readout channels. Each channel uses a two-phase reserve/commit handshake with timeout. The sequencer reads results with per-qubit pending/fresh status so it can tell whether a result is available, new, or stale. It sits between the readout demodulators (write side) and the QC sequencer's measurement-dependent branch logic (read side).

---
 rtl/q_meas_regfile_pkg.sv | 13 +
 rtl/q_meas_regfile_if.sv | 32 +++
 rtl/q_meas_regfile_wr_ch.sv | 74 +++++++
 rtl/q_meas_regfile.sv | 94 +++++++++
 tb/tb_q_meas_regfile.sv | 127 ++++++++++++
 5 files changed

// File: rtl/q_meas_regfile_pkg.sv
// Shared types for the measurement-result register file: channel FSM states
// and bit positions inside measure_data.
package q_meas_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    COMMIT = 2'b10
  } ch_state_t;

  localparam int MD_VALUE   = 0;
  localparam int MD_PENDING = 1;
  localparam int MD_FRESH   = 2;
endpackage

// File: rtl/q_meas_regfile_if.sv
// Bus between readout demodulators / sequencer (master) and the result
// register file (slave).
interface q_meas_regfile_if #(
  parameter int NUM_QUBITS = 32,
  parameter int NUM_WR_CH  = 2,
  parameter int DATA_W     = 64
);
  localparam int ADDR_W = $clog2(NUM_QUBITS);

  logic [NUM_WR_CH-1:0]             wr_en;
  logic [NUM_WR_CH-1:0][ADDR_W-1:0] wr_addr;
  logic [NUM_WR_CH-1:0]             wr_valid;
  logic [NUM_WR_CH-1:0]             wr_data;
  logic [NUM_WR_CH-1:0]             wr_busy;
  logic                             rd_en;
  logic [ADDR_W-1:0]                rd_addr;
  logic                             rd_valid;
  logic [DATA_W-1:0]                measure_data;
  logic                             collision_err;
  logic [NUM_WR_CH-1:0]             timeout_err;
  logic                             err_clr;

  modport master (
    output wr_en, wr_addr, wr_valid, wr_data, rd_en, rd_addr, err_clr,
    input  wr_busy, rd_valid, measure_data, collision_err, timeout_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_valid, wr_data, rd_en, rd_addr, err_clr,
    output wr_busy, rd_valid, measure_data, collision_err, timeout_err
  );
endinterface

// File: rtl/q_meas_regfile_wr_ch.sv
// One readout write channel: reserve/commit FSM with a reservation timeout.
// Exposes its state, reserved address and latched result to the top.
module q_meas_wr_ch
  import q_meas_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_wr_valid,
  input  logic              i_wr_data,
  input  logic              i_err_clr,
  output ch_state_t         o_state,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_data,
  output logic              o_timeout_err
);
  localparam int CNT_W = $clog2(TIMEOUT);

  ch_state_t         r_state, w_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_tout_err;
  logic              w_tout;

  always_comb begin
    w_nxt  = r_state;
    w_tout = 1'b0;
    case (r_state)
      IDLE:   if (i_wr_en) w_nxt = WAIT;
      WAIT: begin
        if (i_wr_valid) begin
          w_nxt = COMMIT;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_nxt  = IDLE;
          w_tout = 1'b1;
        end
      end
      COMMIT: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_data     <= 1'b0;
      r_cnt      <= '0;
      r_tout_err <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && i_wr_en) begin
        r_addr <= i_wr_addr;
        r_cnt  <= '0;
      end else if (r_state == WAIT && !i_wr_valid) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == WAIT && i_wr_valid) r_data <= i_wr_data;
      // a timeout in the same cycle as err_clr keeps the flag set
      if (w_tout)         r_tout_err <= 1'b1;
      else if (i_err_clr) r_tout_err <= 1'b0;
    end
  end

  assign o_state       = r_state;
  assign o_addr        = r_addr;
  assign o_data        = r_data;
  assign o_timeout_err = r_tout_err;
endmodule

// File: rtl/q_meas_regfile.sv
// Measurement-result register file: per-qubit value/fresh storage, commit
// arbitration across write channels, collision detection and the read port.
module q_meas_regfile
  import q_meas_pkg::*;
#(
  parameter int   NUM_QUBITS = 32,
  parameter int   NUM_WR_CH  = 2,
  parameter int   TIMEOUT    = 1024,
  parameter logic RESET_VAL  = 1'b1,
  parameter int   DATA_W     = 64
) (
  input logic              clk,
  input logic              reset,
  q_meas_regfile_if.slave  bus
);
  localparam int ADDR_W = $clog2(NUM_QUBITS);

  ch_state_t             w_state [NUM_WR_CH];
  logic [ADDR_W-1:0]     w_addr  [NUM_WR_CH];
  logic [NUM_WR_CH-1:0]  w_data;
  logic [NUM_WR_CH-1:0]  w_tout_err;
  logic [NUM_WR_CH-1:0]  w_busy;
  logic [NUM_QUBITS-1:0] r_value, r_fresh;
  logic                  r_rd_valid, r_coll;
  logic [DATA_W-1:0]     r_md, w_md;
  logic                  w_coll, w_rd_pend;

  for (genvar c = 0; c < NUM_WR_CH; c++) begin : g_ch
    q_meas_wr_ch #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) u_ch (
      .clk          (clk),
      .reset        (reset),
      .i_wr_en      (bus.wr_en[c]),
      .i_wr_addr    (bus.wr_addr[c]),
      .i_wr_valid   (bus.wr_valid[c]),
      .i_wr_data    (bus.wr_data[c]),
      .i_err_clr    (bus.err_clr),
      .o_state      (w_state[c]),
      .o_addr       (w_addr[c]),
      .o_data       (w_data[c]),
      .o_timeout_err(w_tout_err[c])
    );
    assign w_busy[c] = (w_state[c] != IDLE);
  end

  // pending is derived from live reservations, so overlapping reservations
  // of one qubit stay pending until the last one resolves
  always_comb begin
    w_coll    = 1'b0;
    w_rd_pend = 1'b0;
    for (int i = 0; i < NUM_WR_CH; i++) begin
      if ((w_state[i] == WAIT || w_state[i] == COMMIT) && w_addr[i] == bus.rd_addr)
        w_rd_pend = 1'b1;
      for (int j = i + 1; j < NUM_WR_CH; j++)
        if (w_state[i] == COMMIT && w_state[j] == COMMIT && w_addr[i] == w_addr[j])
          w_coll = 1'b1;
    end
    w_md             = '0;
    w_md[MD_VALUE]   = r_value[bus.rd_addr];
    w_md[MD_PENDING] = w_rd_pend;
    w_md[MD_FRESH]   = r_fresh[bus.rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value    <= {NUM_QUBITS{RESET_VAL}};
      r_fresh    <= '0;
      r_rd_valid <= 1'b0;
      r_md       <= '0;
      r_coll     <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_md                  <= w_md;
        r_fresh[bus.rd_addr]  <= 1'b0;
      end
      // descending scan: lowest channel index is written last and wins;
      // commits also override the clear-on-read above
      for (int c = NUM_WR_CH - 1; c >= 0; c--) begin
        if (w_state[c] == COMMIT) begin
          r_value[w_addr[c]] <= w_data[c];
          r_fresh[w_addr[c]] <= 1'b1;
        end
      end
      if (w_coll)           r_coll <= 1'b1;
      else if (bus.err_clr) r_coll <= 1'b0;
    end
  end

  assign bus.wr_busy       = w_busy;
  assign bus.timeout_err   = w_tout_err;
  assign bus.rd_valid      = r_rd_valid;
  assign bus.measure_data  = r_md;
  assign bus.collision_err = r_coll;
endmodule

// File: tb/tb_q_meas_regfile.sv
// Directed bench for q_meas_regfile: read results are checked against a
// scoreboard queue filled when each read is issued.
module tb_q_meas_regfile;
  localparam int NQ = 32, NCH = 2, DW = 64, TO = 1024;

  logic clk = 1'b0, reset = 1'b1;
  int   total = 0, bad = 0;
  logic exp_vld = 1'b0;
  logic [DW-1:0] sb[$];

  q_meas_regfile_if #(.NUM_QUBITS(NQ), .NUM_WR_CH(NCH), .DATA_W(DW)) bus ();

  q_meas_regfile #(.NUM_QUBITS(NQ), .NUM_WR_CH(NCH), .TIMEOUT(TO),
                   .RESET_VAL(1'b1), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] expv);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 5'(a);
    sb.push_back(expv);
  endtask

  always @(posedge clk) exp_vld <= reset ? 1'b0 : bus.rd_en;

  always @(negedge clk) begin
    chk("rd_valid", DW'(bus.rd_valid), DW'(exp_vld));
    if (bus.rd_valid) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else                chk("measure_data", bus.measure_data, sb.pop_front());
    end
  end

  initial begin
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_valid = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.err_clr = 1'b0;
    tick(); tick();
    chk("rst_busy", DW'(bus.wr_busy), 0);
    chk("rst_md", bus.measure_data, 0);
    chk("rst_coll", DW'(bus.collision_err), 0);
    chk("rst_tout", DW'(bus.timeout_err), 0);
    reset = 1'b0;

    // every entry reads back RESET_VAL, not pending, not fresh
    for (int a = 0; a < NQ; a++) begin rd(a, 64'h1); tick(); end
    bus.rd_en = 1'b0; tick(); tick();

    // ch0 minimum-latency reserve/commit of qubit 5 with data 0
    bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd5; tick();
    chk("busy_wait", DW'(bus.wr_busy), 2'b01);
    bus.wr_en = '0; bus.wr_valid = 2'b01; bus.wr_data = 2'b00;
    rd(5, 64'h3); tick();
    bus.wr_valid = '0; bus.rd_en = 1'b0; tick();
    rd(5, 64'h4); tick();
    rd(5, 64'h0); tick();
    bus.rd_en = 1'b0; tick(); tick();
    chk("busy_idle", DW'(bus.wr_busy), 0);

    // both channels commit qubit 9 together: ch0 (data 1) wins
    bus.wr_en = 2'b11; bus.wr_addr[0] = 5'd9; bus.wr_addr[1] = 5'd9; tick();
    bus.wr_en = '0; bus.wr_valid = 2'b11; bus.wr_data = 2'b01; tick();
    bus.wr_valid = '0; tick();
    chk("coll_set", DW'(bus.collision_err), 1);
    rd(9, 64'h5); tick();
    bus.rd_en = 1'b0; tick();
    chk("coll_sticky", DW'(bus.collision_err), 1);
    bus.err_clr = 1'b1; tick();
    bus.err_clr = 1'b0;
    chk("coll_clr", DW'(bus.collision_err), 0);

    // ch1 reserves qubit 3 and never delivers a result
    bus.wr_en = 2'b10; bus.wr_addr[1] = 5'd3; tick();
    bus.wr_en = '0;
    for (int i = 1; i < TO; i++) begin
      if (i == 1) rd(3, 64'h3); else bus.rd_en = 1'b0;
      tick();
    end
    chk("tout_early", DW'(bus.timeout_err), 0);
    chk("tout_busy_early", DW'(bus.wr_busy), 2'b10);
    tick();
    chk("tout_set", DW'(bus.timeout_err), 2'b10);
    chk("tout_busy", DW'(bus.wr_busy), 0);
    rd(3, 64'h1); tick();
    bus.rd_en = 1'b0; bus.err_clr = 1'b1; tick();
    bus.err_clr = 1'b0;
    chk("tout_clr", DW'(bus.timeout_err), 0);

    // read and commit of qubit 7 in the same cycle
    bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd7; tick();
    bus.wr_en = '0; bus.wr_valid = 2'b01; bus.wr_data = 2'b00; tick();
    bus.wr_valid = '0; rd(7, 64'h3); tick();
    rd(7, 64'h4); tick();
    bus.rd_en = 1'b0; tick(); tick();

    // reset while ch0 waits on qubit 12; a late wr_valid is ignored
    bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd12; tick();
    bus.wr_en = '0;
    chk("pre_rst_busy", DW'(bus.wr_busy), 2'b01);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("mid_rst_busy", DW'(bus.wr_busy), 0);
    bus.wr_valid = 2'b01; bus.wr_data = 2'b00; tick();
    bus.wr_valid = '0; tick(); tick();
    rd(12, 64'h1); tick();
    rd(9, 64'h1); tick();
    bus.rd_en = 1'b0; tick(); tick();

    chk("sb_drained", DW'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
